// File: rtl/aes_128_pkg.sv
// Shared AES-128 constants, key-schedule state encoding and S-box.
// Used by the key expander and the round datapath.
package aes_128_pkg;

  localparam int AES_NR    = 10;
  localparam int KEYRAM_AW = 5;

  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] RCON_POLY = 8'h1b;

  typedef enum logic [1:0] {
    KS_IDLE  = 2'd0,
    KS_WR_HI = 2'd1,
    KS_WR_LO = 2'd2,
    KS_SUB   = 2'd3
  } key_state_e;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[x];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? RCON_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/aes_128_key_expand_if.sv
// Key RAM write port carried from the key expander to aes_128_keyram.
// Master drives the strobe, address and data.
interface aes_128_key_expand_if;
  import aes_128_pkg::*;

  logic                 en_wr;
  logic [KEYRAM_AW-1:0] addr_wr;
  logic [63:0]          key_round_wr;

  modport master (
    output en_wr,
    output addr_wr,
    output key_round_wr
  );

  modport slave (
    input en_wr,
    input addr_wr,
    input key_round_wr
  );

endinterface

// File: rtl/aes_128_key_subword.sv
// Combinational SubWord: four parallel S-box lookups on a 32-bit word.
module aes_128_key_subword
  import aes_128_pkg::*;
(
  input  logic [31:0] word,
  output logic [31:0] sub
);

  assign sub = {sbox(word[31:24]), sbox(word[23:16]),
                sbox(word[15:8]),  sbox(word[7:0])};

endmodule

// File: rtl/aes_128_key_expand.sv
// AES-128 key schedule: 3 cycles per round key, two 64-bit RAM writes each.
// Define AES_KEYEXP_DEC_ORDER_EN to store round keys in decryption order.
module aes_128_key_expand
  import aes_128_pkg::*;
(
  input  logic                  clk,
  input  logic                  kill,
  input  logic                  key_start,
  input  logic [127:0]          key_in,
  output logic                  busy,
  output logic                  key_ready,
  aes_128_key_expand_if.master  wr
);

  localparam logic [1:0] IDLE  = KS_IDLE;
  localparam logic [1:0] WR_HI = KS_WR_HI;
  localparam logic [1:0] WR_LO = KS_WR_LO;
  localparam logic [1:0] SUB   = KS_SUB;

  localparam logic [3:0] LAST_R = 4'(AES_NR);

  logic [1:0]           state;
  logic [3:0]           r;
  logic [7:0]           rcon;
  logic [127:0]         rk_reg;
  logic                 en_wr;
  logic [KEYRAM_AW-1:0] addr_wr;
  logic [63:0]          key_round_wr;

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] sw, t;
  logic [31:0] n0, n1, n2, n3;
  logic [127:0] rk_next;

  function automatic logic [KEYRAM_AW-1:0] waddr(
    input logic [3:0] rr,
    input logic       h
  );
`ifdef AES_KEYEXP_DEC_ORDER_EN
    return {LAST_R - rr, h};
`else
    return {rr, h};
`endif
  endfunction

  assign {w0, w1, w2, w3} = rk_reg;

  aes_128_key_subword u_subword (
    .word ({w3[23:0], w3[31:24]}),
    .sub  (sw)
  );

  assign t  = sw ^ {rcon, 24'h0};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign rk_next = {n0, n1, n2, n3};

  assign busy            = (state != IDLE);
  assign wr.en_wr        = en_wr;
  assign wr.addr_wr      = addr_wr;
  assign wr.key_round_wr = key_round_wr;

  // Write-port registers are loaded one edge ahead of the state they belong to.
  always_ff @(posedge clk) begin
    if (kill) begin
      state        <= IDLE;
      r            <= 4'd0;
      rcon         <= 8'h00;
      rk_reg       <= 128'h0;
      en_wr        <= 1'b0;
      addr_wr      <= '0;
      key_round_wr <= 64'h0;
      key_ready    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          en_wr <= 1'b0;
          if (key_start) begin
            state        <= WR_HI;
            r            <= 4'd0;
            rcon         <= RCON_INIT;
            rk_reg       <= key_in;
            key_ready    <= 1'b0;
            en_wr        <= 1'b1;
            addr_wr      <= waddr(4'd0, 1'b0);
            key_round_wr <= key_in[127:64];
          end
        end
        WR_HI: begin
          state        <= WR_LO;
          en_wr        <= 1'b1;
          addr_wr      <= waddr(r, 1'b1);
          key_round_wr <= rk_reg[63:0];
        end
        WR_LO: begin
          en_wr <= 1'b0;
          if (r < LAST_R) begin
            state <= SUB;
          end else begin
            state     <= IDLE;
            key_ready <= 1'b1;
          end
        end
        SUB: begin
          state        <= WR_HI;
          r            <= r + 4'd1;
          rcon         <= xtime(rcon);
          rk_reg       <= rk_next;
          en_wr        <= 1'b1;
          addr_wr      <= waddr(r + 4'd1, 1'b0);
          key_round_wr <= rk_next[127:64];
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_128_key_expand.sv
// Directed bench for aes_128_key_expand: FIPS-197 vectors, timing, kill, rekey.
module tb_aes_128_key_expand;

  logic         clk = 1'b0;
  logic         kill;
  logic         key_start;
  logic [127:0] key_in;
  logic         busy;
  logic         key_ready;

  aes_128_key_expand_if wr_if ();

  aes_128_key_expand dut (
    .clk       (clk),
    .kill      (kill),
    .key_start (key_start),
    .key_in    (key_in),
    .busy      (busy),
    .key_ready (key_ready),
    .wr        (wr_if)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] KEY_A1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_ZERO = 128'h0;

  typedef struct {
    int          kid;
    int          addr;
    logic [63:0] data;
  } vec_t;

  vec_t        tbl [10];
  logic [63:0] ram [22];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string nm, input logic [127:0] got,
                     input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  // Natural-order address of a round-key half -> where it lands in the RAM.
  function automatic int map_addr(input int a);
`ifdef AES_KEYEXP_DEC_ORDER_EN
    return 20 - (a - a % 2) + a % 2;
`else
    return a;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expand(input logic [127:0] k, input bit glitch,
                        input string nm);
    int pulses, busyc, bad_en, rc;
    foreach (ram[i]) ram[i] = 'x;
    key_in    = k;
    key_start = 1'b1;
    tick();
    key_start = 1'b0;
    key_in    = ~k;
    pulses = 0; busyc = 0; bad_en = 0; rc = 0;
    chk({nm, " ready_clr"}, key_ready, 1'b0);
    for (int c = 1; c <= 40; c++) begin
      if (key_ready === 1'b1) begin
        rc = c;
        break;
      end
      if (busy === 1'b1) busyc++;
      if (wr_if.en_wr !== ((c % 3) != 0)) bad_en++;
      if (wr_if.en_wr === 1'b1) begin
        pulses++;
        if (wr_if.addr_wr < 5'd22) ram[wr_if.addr_wr] = wr_if.key_round_wr;
      end
      key_start = glitch && (c == 5 || c == 20);
      tick();
    end
    key_start = 1'b0;
    chk({nm, " ready_cycle"}, rc, 33);
    chk({nm, " pulses"}, pulses, 22);
    chk({nm, " busy_cycles"}, busyc, 32);
    chk({nm, " en_pattern_bad"}, bad_en, 0);
    chk({nm, " busy_end"}, busy, 1'b0);
  endtask

  task automatic check_tbl(input int kid, input string nm);
    foreach (tbl[i]) begin
      if (tbl[i].kid == kid)
        chk($sformatf("%s addr%0d", nm, map_addr(tbl[i].addr)),
            ram[map_addr(tbl[i].addr)], tbl[i].data);
    end
  endtask

  task automatic check_zero_outs(input string nm);
    chk({nm, " en_wr"}, wr_if.en_wr, 1'b0);
    chk({nm, " addr_wr"}, wr_if.addr_wr, 5'd0);
    chk({nm, " data"}, wr_if.key_round_wr, 64'h0);
    chk({nm, " key_ready"}, key_ready, 1'b0);
    chk({nm, " busy"}, busy, 1'b0);
  endtask

  initial begin
    tbl[0] = '{0, 0,  64'h2b7e151628aed2a6};
    tbl[1] = '{0, 1,  64'habf7158809cf4f3c};
    tbl[2] = '{0, 2,  64'ha0fafe1788542cb1};
    tbl[3] = '{0, 3,  64'h23a339392a6c7605};
    tbl[4] = '{0, 20, 64'hd014f9a8c9ee2589};
    tbl[5] = '{0, 21, 64'he13f0cc8b6630ca6};
    tbl[6] = '{1, 2,  64'h6263636362636363};
    tbl[7] = '{1, 3,  64'h6263636362636363};
    tbl[8] = '{1, 20, 64'hb4ef5bcb3e92e211};
    tbl[9] = '{1, 21, 64'h23e951cf6f8f188e};

    kill      = 1'b1;
    key_start = 1'b0;
    key_in    = '0;
    tick();
    tick();
    check_zero_outs("reset");
    kill = 1'b0;
    tick();

    expand(KEY_A1, 1'b1, "a1");
    check_tbl(0, "a1");

    key_in    = KEY_A1;
    key_start = 1'b1;
    tick();
    key_start = 1'b0;
    repeat (14) tick();
    chk("mid_busy", busy, 1'b1);
    kill = 1'b1;
    tick();
    kill = 1'b0;
    check_zero_outs("kill");

    kill      = 1'b1;
    key_start = 1'b1;
    tick();
    kill      = 1'b0;
    key_start = 1'b0;
    chk("kill_wins busy", busy, 1'b0);
    chk("kill_wins en", wr_if.en_wr, 1'b0);

    expand(KEY_A1, 1'b0, "a1_post_kill");
    check_tbl(0, "a1_post_kill");

    chk("rekey ready_before", key_ready, 1'b1);
    expand(KEY_ZERO, 1'b0, "zero");
    check_tbl(1, "zero");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
